// File: rtl/mio_bus_pkg.sv
// ---------------------------------------------------------------------------
// mio_bus_pkg
// Shared definitions for the two-master memory/IO bus arbiter: FSM state
// encoding, one-hot grant codes and the round-robin pick function.
// ---------------------------------------------------------------------------
package mio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // req is {m1_req, m0_req}; on a tie the master that did not own the bus
    // last time wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                           input logic [1:0] last_gnt);
        logic [1:0] pick;
        case (req)
            2'b01:   pick = GNT_M0;
            2'b10:   pick = GNT_M1;
            2'b11:   pick = (last_gnt == GNT_M0) ? GNT_M1 : GNT_M0;
            default: pick = GNT_NONE;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mio_bus_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Counts cycles while a bus transaction is outstanding and flags expiry on
// the TIMEOUT-th enabled cycle after a clear. TIMEOUT=0 disables expiry.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart count at zero (asserted on grant)
//   en          count this cycle (slave transaction outstanding)
//   expired     count has reached TIMEOUT-1 while enabled
// ---------------------------------------------------------------------------
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TC = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    // Holding at the terminal value keeps the counter from ever wrapping,
    // even if the owner were to stay enabled past expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != TC)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && en && (cnt == TC);

endmodule

// File: rtl/mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter
// Two-master round-robin arbiter for the single memory/IO bus behind the
// multi-cycle CPU. M0 is the CPU memory port, M1 a secondary master
// (DMA/VGA fetch). The winner's request is registered onto the slave bus,
// the arbiter waits for s_ready (guarded by a watchdog) and returns read
// data plus a one-cycle ready/err pulse to the owning master only.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        master request side (X = 0, 1)
//   mX_rdata/ready/err          master response side, rdata is 0 unless ready
//   s_req/we/addr/wdata         registered slave request
//   s_rdata, s_ready            slave response, only looked at in BUSY
//   grant                       one-hot owner {M1,M0}, 00 when idle
//   state                       FSM state for debug display
//
// FSM states:
//   state   | meaning
//   ST_IDLE | bus free, arbitrate between pending requests
//   ST_BUSY | slave request outstanding, watchdog running
//   ST_RESP | one-cycle ready/err pulse to the owning master
// ---------------------------------------------------------------------------
module mio_bus_arbiter
    import mio_bus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          m1_err,
    output logic          s_req,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic [1:0]    grant,
    output logic [1:0]    state
);

    state_t        cur_st;
    state_t        nxt_st;
    logic [1:0]    last_gnt;
    logic [1:0]    pick;
    logic          accept;
    logic [DW-1:0] rdata_reg;
    logic          err_reg;
    logic          wd_expired;

    assign pick   = rr_pick({m1_req, m0_req}, last_gnt);
    assign accept = (cur_st == ST_IDLE) && (pick != GNT_NONE);
    assign state  = cur_st;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .en      (cur_st == ST_BUSY),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE: if (pick != GNT_NONE)        nxt_st = ST_BUSY;
            ST_BUSY: if (s_ready || wd_expired)   nxt_st = ST_RESP;
            ST_RESP:                              nxt_st = ST_IDLE;
            default:                              nxt_st = ST_IDLE;
        endcase
    end

    // Request/response registers. s_we/s_addr/s_wdata are only loaded on
    // the grant edge, so they stay stable for the whole BUSY period even if
    // the master changes its inputs or drops its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_req     <= 1'b0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            grant     <= GNT_NONE;
            last_gnt  <= GNT_M1;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (cur_st)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        s_req   <= 1'b1;
                        grant   <= pick;
                        s_we    <= (pick == GNT_M1) ? m1_we    : m0_we;
                        s_addr  <= (pick == GNT_M1) ? m1_addr  : m0_addr;
                        s_wdata <= (pick == GNT_M1) ? m1_wdata : m0_wdata;
                    end
                end
                ST_BUSY: begin
                    // A slave completion on the expiry cycle still counts as
                    // a good transfer.
                    if (s_ready) begin
                        s_req     <= 1'b0;
                        rdata_reg <= s_rdata;
                        err_reg   <= 1'b0;
                    end else if (wd_expired) begin
                        s_req     <= 1'b0;
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    last_gnt <= grant;
                    grant    <= GNT_NONE;
                end
                default: begin
                    s_req <= 1'b0;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Responses are decoded from the RESP state so an asynchronous reset
    // can never leave a stray ready pulse behind.
    always_comb begin
        m0_ready = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        if (cur_st == ST_RESP) begin
            if (grant == GNT_M0) begin
                m0_ready = 1'b1;
                m0_err   = err_reg;
                m0_rdata = rdata_reg;
            end else if (grant == GNT_M1) begin
                m1_ready = 1'b1;
                m1_err   = err_reg;
                m1_rdata = rdata_reg;
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
module tb_mio_bus_arbiter;
    import mio_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant, state;

    int vectors = 0;
    int misses  = 0;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mio_bus_arbiter #(
        .AW (32), .DW (32), .TIMEOUT (8)
    ) dut (
        .clk      (clk),      .rst_n    (rst_n),
        .m0_req   (m0_req),   .m0_we    (m0_we),    .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata), .m0_rdata (m0_rdata), .m0_ready (m0_ready),
        .m0_err   (m0_err),
        .m1_req   (m1_req),   .m1_we    (m1_we),    .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata), .m1_rdata (m1_rdata), .m1_ready (m1_ready),
        .m1_err   (m1_err),
        .s_req    (s_req),    .s_we     (s_we),     .s_addr   (s_addr),
        .s_wdata  (s_wdata),  .s_rdata  (s_rdata),  .s_ready  (s_ready),
        .grant    (grant),    .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Looks for a ready pulse now or within 'budget' further negedges,
    // then pops the scoreboard and compares owner, data and error flag.
    task automatic wait_resp(input string tag, input int budget);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (m0_ready || m1_ready) begin
                seen = 1'b1;
                break;
            end
            if (i < budget) @(negedge clk);
        end
        if (!seen) begin
            vectors++;
            misses++;
            $error("FAIL %s_wait observed=no_ready expected=ready_pulse", tag);
        end else if (sb.size() == 0) begin
            vectors++;
            misses++;
            $error("FAIL %s_sb observed=ready expected=no_pending_entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_who"},   64'({m1_ready, m0_ready}), 64'(e.who));
            chk({tag, "_rdata"}, 64'((e.who == GNT_M1) ? m1_rdata : m0_rdata), 64'(e.rdata));
            chk({tag, "_err"},   64'((e.who == GNT_M1) ? m1_err : m0_err), 64'(e.err));
            chk({tag, "_other"}, 64'((e.who == GNT_M1) ? m0_rdata : m1_rdata), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=still_running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [1:0] g;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(state), 64'(ST_IDLE));
        chk("rst_grant", 64'(grant), 64'(GNT_NONE));
        chk("rst_sreq",  64'(s_req), 64'(0));
        chk("rst_saddr", 64'(s_addr), 64'(0));
        chk("rst_ready", 64'({m1_ready, m0_ready}), 64'(0));
        chk("rst_rdata", 64'({m1_rdata, m0_rdata}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // M0 read, zero-wait slave
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
        @(negedge clk);
        chk("t2_state", 64'(state), 64'(ST_BUSY));
        chk("t2_sreq",  64'(s_req), 64'(1));
        chk("t2_grant", 64'(grant), 64'(GNT_M0));
        chk("t2_saddr", 64'(s_addr), 64'(32'h0000_0010));
        chk("t2_swe",   64'(s_we), 64'(0));
        chk("t2_early", 64'(m0_ready), 64'(0));
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        sb.push_back(exp_t'{GNT_M0, 32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        wait_resp("t2", 0);
        chk("t2_resp_state", 64'(state), 64'(ST_RESP));
        chk("t2_resp_sreq",  64'(s_req), 64'(0));
        m0_req = 0; s_ready = 0; s_rdata = 0;
        @(negedge clk);
        chk("t2_idle",  64'(state), 64'(ST_IDLE));
        chk("t2_pulse", 64'({m1_ready, m0_ready}), 64'(0));
        chk("t2_gnone", 64'(grant), 64'(GNT_NONE));

        // M1 write, 3-wait slave; master inputs change mid-BUSY
        m1_req = 1; m1_we = 1; m1_addr = 32'h8000_0000; m1_wdata = 32'h1234_5678;
        s_rdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_state",  64'(state), 64'(ST_BUSY));
            chk("t4_grant",  64'(grant), 64'(GNT_M1));
            chk("t4_sreq",   64'(s_req), 64'(1));
            chk("t4_swe",    64'(s_we), 64'(1));
            chk("t4_saddr",  64'(s_addr), 64'(32'h8000_0000));
            chk("t4_swdata", 64'(s_wdata), 64'(32'h1234_5678));
            chk("t4_early",  64'(m1_ready), 64'(0));
            if (i == 1) begin
                m1_we = 0; m1_addr = 32'h0000_0ABC; m1_wdata = 32'h0;
            end
            if (i == 3) begin
                s_ready = 1;
                sb.push_back(exp_t'{GNT_M1, 32'hA5A5_A5A5, 1'b0});
            end
        end
        @(negedge clk);
        wait_resp("t4", 0);
        m1_req = 0; s_ready = 0;
        @(negedge clk);

        // tie: both request continuously, grants alternate starting with M0
        m0_req = 1; m0_addr = 32'h0000_0100;
        m1_req = 1; m1_addr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? GNT_M0 : GNT_M1;
            @(negedge clk);
            chk("t3_grant", 64'(grant), 64'(g));
            chk("t3_saddr", 64'(s_addr), 64'((g == GNT_M0) ? 32'h0000_0100 : 32'h0000_0200));
            s_ready = 1; s_rdata = 32'h0000_1000 + 32'(k);
            sb.push_back(exp_t'{g, 32'h0000_1000 + 32'(k), 1'b0});
            @(negedge clk);
            wait_resp("t3", 0);
            s_ready = 0;
            if (k == 3) begin
                m0_req = 0; m1_req = 0;
            end
            @(negedge clk);
        end

        // watchdog expiry after exactly 8 BUSY cycles
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0044; s_rdata = 32'hFFFF_FFFF;
        sb.push_back(exp_t'{GNT_M0, 32'h0, 1'b1});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_busy",  64'(state), 64'(ST_BUSY));
            chk("t5_early", 64'(m0_ready), 64'(0));
        end
        @(negedge clk);
        wait_resp("t5", 0);
        m0_req = 0;
        @(negedge clk);
        chk("t5_idle", 64'(state), 64'(ST_IDLE));

        // s_ready on the expiry cycle wins; M0 drops req while BUSY
        m0_req = 1; m0_addr = 32'h0000_0048; s_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_busy", 64'(state), 64'(ST_BUSY));
            if (i == 1) m0_req = 0;
            if (i == 7) begin
                s_ready = 1;
                sb.push_back(exp_t'{GNT_M0, 32'hCAFE_F00D, 1'b0});
            end
        end
        @(negedge clk);
        wait_resp("t6", 0);
        s_ready = 0;
        @(negedge clk);
        chk("t6_idle", 64'(state), 64'(ST_IDLE));

        // reset in the middle of an M1 transaction
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0300;
        @(negedge clk);
        chk("t1_busy",  64'(state), 64'(ST_BUSY));
        chk("t1_grant", 64'(grant), 64'(GNT_M1));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_sreq",  64'(s_req), 64'(0));
        chk("t1_gnone", 64'(grant), 64'(GNT_NONE));
        chk("t1_state", 64'(state), 64'(ST_IDLE));
        chk("t1_ready", 64'({m1_ready, m0_ready}), 64'(0));
        m0_req = 1;
        @(negedge clk);
        chk("t1_ready_hold", 64'({m1_ready, m0_ready}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_tie_m0", 64'(grant), 64'(GNT_M0));
        s_ready = 1; s_rdata = 32'h0BAD_CAFE;
        sb.push_back(exp_t'{GNT_M0, 32'h0BAD_CAFE, 1'b0});
        @(negedge clk);
        wait_resp("t1", 0);
        m0_req = 0; m1_req = 0; s_ready = 0;
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
